// File: rtl/ahb_dual_master_arb.sv
// rtl/ahb_dual_master_arb.sv - two-master AHB-Lite round-robin arbiter with a one-entry address hold per master
module ahb_dual_master_arb #(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] HADDR_M0,
  input  logic [1:0]    HTRANS_M0,
  input  logic          HWRITE_M0,
  input  logic [2:0]    HSIZE_M0,
  input  logic [31:0]   HWDATA_M0,
  output logic          HREADY_M0,
  output logic          HRESP_M0,
  output logic [31:0]   HRDATA_M0,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [31:0]   HWDATA_M1,
  output logic          HREADY_M1,
  output logic          HRESP_M1,
  output logic [31:0]   HRDATA_M1,
  output logic          HSEL_S,
  output logic [AW-1:0] HADDR_S,
  output logic [1:0]    HTRANS_S,
  output logic          HWRITE_S,
  output logic [2:0]    HSIZE_S,
  output logic [31:0]   HWDATA_S,
  output logic          HREADY_S,
  input  logic          HREADYOUT_S,
  input  logic          HRESP_S,
  input  logic [31:0]   HRDATA_S
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          write;
    logic [2:0]    size;
  } addr_phase_t;

  addr_phase_t   bus0, bus1, hold0, hold1, src;
  logic          pend0, pend1;
  logic          dp_valid, dp_own, rr;
  logic          live0, live1, req0, req1;
  logic          arb_en, gnt0, gnt1, gnt_any;
  logic          src_live, seq_cont;
  logic [AW-1:0] last_addr;
  logic          last_write;
  logic [2:0]    last_size;

  assign bus0 = {HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0};
  assign bus1 = {HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1};

  assign HREADY_M0 = pend0 ? 1'b0 : ((dp_valid && !dp_own) ? HREADYOUT_S : 1'b1);
  assign HREADY_M1 = pend1 ? 1'b0 : ((dp_valid &&  dp_own) ? HREADYOUT_S : 1'b1);

  assign HRESP_M0  = dp_valid && !dp_own && HRESP_S;
  assign HRESP_M1  = dp_valid &&  dp_own && HRESP_S;
  assign HRDATA_M0 = HRDATA_S;
  assign HRDATA_M1 = HRDATA_S;

  assign live0 = HTRANS_M0[1] & HREADY_M0;
  assign live1 = HTRANS_M1[1] & HREADY_M1;
  assign req0  = pend0 | live0;
  assign req1  = pend1 | live1;

  // rr is the last-granted master; on a tie the other one wins
  assign arb_en  = HREADYOUT_S & ~HRESET;
  assign gnt0    = arb_en & req0 & (~req1 |  rr);
  assign gnt1    = arb_en & req1 & (~req0 | ~rr);
  assign gnt_any = gnt0 | gnt1;

  always_comb begin
    src      = bus0;
    src_live = 1'b1;
    if (gnt1) begin
      src      = pend1 ? hold1 : bus1;
      src_live = ~pend1;
    end else begin
      src      = pend0 ? hold0 : bus0;
      src_live = ~pend0;
    end
  end

  // a replayed transfer always restarts the burst, so only live SEQ beats keep SEQ
  assign seq_cont = src_live && (src.trans == TRANS_SEQ) && (dp_own == gnt1);

  assign HSEL_S   = gnt_any;
  assign HTRANS_S = !gnt_any ? TRANS_IDLE : (seq_cont ? TRANS_SEQ : TRANS_NONSEQ);
  assign HADDR_S  = gnt_any ? src.addr  : last_addr;
  assign HWRITE_S = gnt_any ? src.write : last_write;
  assign HSIZE_S  = gnt_any ? src.size  : last_size;
  assign HWDATA_S = dp_own ? HWDATA_M1 : HWDATA_M0;
  assign HREADY_S = HREADYOUT_S;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      dp_valid   <= 1'b0;
      dp_own     <= 1'b0;
      rr         <= 1'b1;
      last_addr  <= '0;
      last_write <= 1'b0;
      last_size  <= 3'b000;
    end else begin
      if (gnt0)       pend0 <= 1'b0;
      else if (live0) pend0 <= 1'b1;
      if (gnt1)       pend1 <= 1'b0;
      else if (live1) pend1 <= 1'b1;
      if (HREADYOUT_S) begin
        dp_valid <= gnt_any;
        if (gnt_any) begin
          dp_own <= gnt1;
          rr     <= gnt1;
        end
      end
      if (gnt_any) begin
        last_addr  <= src.addr;
        last_write <= src.write;
        last_size  <= src.size;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (live0 && !gnt0) hold0 <= bus0;
    if (live1 && !gnt1) hold1 <= bus1;
  end

endmodule

// File: doc/ahb_dual_master_arb.md
Name: ahb_dual_master_arb

Overview:
- Two-master-to-one-slave AHB-Lite arbiter.
- Sits directly upstream of the on-chip SRAM bridge and lets CPU core and DMA engine share one SRAM port.
- Each master has a single-entry address hold stage. A master that loses arbitration, or arrives while the slave is stalled, has its transfer captured and is wait-stated until that transfer completes.
- Arbitration is per transfer, round-robin.

Parameters:
AW  32  address width, all HADDR ports

Ports:
HCLK  in  1  bus clock
HRESET  in  1  synchronous active-high reset
HADDR_M0/HADDR_M1  in  AW  master address
HTRANS_M0/HTRANS_M1  in  2  master transfer type
HWRITE_M0/HWRITE_M1  in  1  master write
HSIZE_M0/HSIZE_M1  in  3  master size
HWDATA_M0/HWDATA_M1  in  32  master write data (data phase)
HREADY_M0/HREADY_M1  out  1  ready to master
HRESP_M0/HRESP_M1  out  1  response to master
HRDATA_M0/HRDATA_M1  out  32  read data to master
HSEL_S  out  1  slave select
HADDR_S  out  AW  slave address
HTRANS_S  out  2  slave transfer type
HWRITE_S  out  1  slave write
HSIZE_S  out  3  slave size
HWDATA_S  out  32  slave write data
HREADY_S  out  1  slave HREADY input
HREADYOUT_S  in  1  slave ready
HRESP_S  in  1  slave response
HRDATA_S  in  32  slave read data

Behaviour:
- Reset: one clock, synchronous, active-high (HRESET, sampled on HCLK rising edge).
  - Reset clears both pend bits, dp_valid and the rr pointer; rr favours M0 first.
  - Outputs after reset: HREADY_Mx=1, HRESP_Mx=0, HSEL_S=0, HTRANS_S=00.
  - Reset mid-transfer silently drops held and in-flight transfers.
- State per master x:
  - pend_x: held transfer valid.
  - hold_x: {addr, trans, write, size} of the held transfer.
- Shared state:
  - dp_valid: a slave data phase is in progress.
  - dp_own: master owning that data phase.
  - rr: last-granted master.
- HREADY_Mx:
  - pend_x=1 -> 0.
  - Else dp_valid and dp_own==x -> HREADYOUT_S.
  - Else 1.
- HRESP_Mx: HRESP_S when dp_valid and dp_own==x, else 0. Two-cycle ERROR is passed through unchanged.
- Request:
  - live_x = HTRANS_Mx[1] & HREADY_Mx; BUSY and IDLE are not requests.
  - req_x = pend_x | live_x.
- Grant, evaluated only when HREADYOUT_S=1:
  - One requester -> that master.
  - Both -> the master != rr.
  - rr updates to the granted master.
- Slave address phase:
  - Granted master's hold_x if pend_x, else its live bus.
  - HSEL_S=1.
  - HTRANS_S = 10 (NONSEQ) unless the source is live, is SEQ, and the master == dp_own; then 11.
  - No grant -> HSEL_S=0, HTRANS_S=00, address outputs hold last value.
- Capture:
  - A live_x that is not granted this cycle is written into hold_x with pend_x set, combinationally zero-latency from the master's view.
  - This covers losing arbitration and HREADYOUT_S=0.
  - pend_x clears on the edge where the held transfer is granted with HREADYOUT_S=1.
- Data phase:
  - On the edge with HREADYOUT_S=1: dp_valid <= grant_any, dp_own <= granted master.
  - HWDATA_S = HWDATA_M[dp_own].
  - HRDATA_S is broadcast to both masters.
- Mx data phase for a held transfer: HREADY_Mx stays 0 from capture until the slave data phase of that transfer completes (dp_own==x, HREADYOUT_S=1).
  - The master holds HWDATA across the stall, so HWDATA_S is valid.
- HREADY_S = HREADYOUT_S.
- Latency:
  - Uncontended transfer: zero added cycles.
  - Losing master: at least one added wait state per contended transfer.
- Simultaneous events:
  - Both masters live, no pend -> rr decides and the loser is captured.
  - A pending transfer and a live transfer on the other master are arbitrated as equals.

Test Plan:
- Reset with HTRANS_M0=10 live -> HSEL_S=0, HREADY_M0=1 during reset. First post-reset NONSEQ reaches HADDR_S the same cycle.
- M0 only, write 0x0000_0010 = 0xDEADBEEF, then read 0x10 -> HSEL_S each cycle, no M0 wait states, HWDATA_S=0xDEADBEEF in data phase, HRDATA_M0 = slave data.
- Same-cycle NONSEQ from both, rr=M1, M0 addr 0x100, M1 addr 0x200:
  - Slave sees 0x100 first, then 0x200.
  - HREADY_M1=0 for one cycle.
  - rr alternates over 4 back-to-back contended pairs.
- M1 captured while HREADYOUT_S=0 for 3 cycles -> pend_1=1, held address is issued when the stall ends, and HWDATA_S takes HWDATA_M1 in its data phase.
- M0 4-beat INCR at 0x40 interleaved with M1 single at 0x80 -> HTRANS_S=10 on the beat after each owner switch, else 11. All data correct.
- Reset asserted while pend_1=1 and dp_valid=1 -> next cycle pend_1=0, HREADY_M1=1, and no stale transfer is issued.
